// File: rtl/dds_frq_sched.sv
// Frequency scheduler for the dds2k24 32-bit DDS.
// Drives the DDS tuning word and phase clear from host commands taken over a strobe/ready
// handshake: phase-continuous retune, retune with phase clear, stepped linear sweep, stop.
// Optional feature macro: DDS_SWEEP_EN enables the SWEEP op and its step/dwell/count datapath.
// Without it, op 2'b10 behaves exactly as SET.
module dds_frq_sched #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned CLR_CYC = 4
) (
    input  logic               sclk_i,
    input  logic               rst_ni,
    input  logic               cmd_stb_i,
    output logic               cmd_rdy_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [31:0]        cmd_frq_i,
    input  logic [31:0]        cmd_stp_i,
    input  logic [CNT_W-1:0]   cmd_cnt_i,
    input  logic [DWELL_W-1:0] cmd_dwl_i,
    output logic [31:0]        frq_o,
    output logic               dds_rst_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClr   = 2'd1;
`ifdef DDS_SWEEP_EN
    localparam logic [1:0] StSweep = 2'd2;
`endif

    localparam logic [1:0] OpSet    = 2'b00;
    localparam logic [1:0] OpSetClr = 2'b01;
    localparam logic [1:0] OpSweep  = 2'b10;
    localparam logic [1:0] OpStop   = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [31:0] frq_q, frq_d;
    logic        dds_rst_q, dds_rst_d;
    logic        done_q, done_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  clr_cnt_q, clr_cnt_d;
    logic        accept;

`ifdef DDS_SWEEP_EN
    logic [31:0]        stp_q, stp_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    // Dwell reload value and down-counter both hold (dwell - 1).
    logic [DWELL_W-1:0] dwl_q, dwl_d;
    logic [DWELL_W-1:0] dwl_cnt_q, dwl_cnt_d;
    logic [DWELL_W-1:0] dwl_m1;

    assign dwl_m1 = (cmd_dwl_i == '0) ? '0 : cmd_dwl_i - DWELL_W'(1);
`else
    logic unused_sweep;
    assign unused_sweep = ^{cmd_stp_i, cmd_cnt_i, cmd_dwl_i};
`endif

    assign accept = cmd_stb_i && rdy_q;

    // Next-state: an accepted command always wins over the current state's own progress.
    always_comb begin
        state_d   = state_q;
        frq_d     = frq_q;
        dds_rst_d = dds_rst_q;
        done_d    = 1'b0;
        clr_cnt_d = clr_cnt_q;
`ifdef DDS_SWEEP_EN
        stp_d     = stp_q;
        rem_d     = rem_q;
        dwl_d     = dwl_q;
        dwl_cnt_d = dwl_cnt_q;
`endif
        if (accept) begin
            unique case (cmd_op_i)
                OpSet: begin
                    frq_d   = cmd_frq_i;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                OpSetClr: begin
                    frq_d     = cmd_frq_i;
                    dds_rst_d = 1'b1;
                    clr_cnt_d = 8'(CLR_CYC - 1);
                    state_d   = StClr;
                end
                OpSweep: begin
                    frq_d = cmd_frq_i;
`ifdef DDS_SWEEP_EN
                    if (cmd_cnt_i == '0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stp_d     = cmd_stp_i;
                        rem_d     = cmd_cnt_i;
                        dwl_d     = dwl_m1;
                        dwl_cnt_d = dwl_m1;
                        state_d   = StSweep;
                    end
`else
                    done_d  = 1'b1;
                    state_d = StIdle;
`endif
                end
                OpStop: begin
                    // Frequency stays where it is; any pending sweep step is dropped.
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end else begin
            case (state_q)
                StClr: begin
                    if (clr_cnt_q == 8'd0) begin
                        dds_rst_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        clr_cnt_d = clr_cnt_q - 8'd1;
                    end
                end
`ifdef DDS_SWEEP_EN
                StSweep: begin
                    if (dwl_cnt_q == '0) begin
                        frq_d     = frq_q + stp_q;
                        dwl_cnt_d = dwl_q;
                        rem_d     = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        dwl_cnt_d = dwl_cnt_q - DWELL_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
        rdy_d = (state_d != StClr);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sclk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            frq_q     <= '0;
            dds_rst_q <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
            clr_cnt_q <= '0;
`ifdef DDS_SWEEP_EN
            stp_q     <= '0;
            rem_q     <= '0;
            dwl_q     <= '0;
            dwl_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            frq_q     <= frq_d;
            dds_rst_q <= dds_rst_d;
            done_q    <= done_d;
            rdy_q     <= rdy_d;
            clr_cnt_q <= clr_cnt_d;
`ifdef DDS_SWEEP_EN
            stp_q     <= stp_d;
            rem_q     <= rem_d;
            dwl_q     <= dwl_d;
            dwl_cnt_q <= dwl_cnt_d;
`endif
        end
    end

    assign cmd_rdy_o = rdy_q;
    assign frq_o     = frq_q;
    assign dds_rst_o = dds_rst_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;

endmodule
